// File: rtl/d_mem_lsu.sv
// rtl/d_mem_lsu.sv - RV32 load/store unit driving a word-wide d_mem port.
// Boundary-crossing accesses become two word accesses through an IDLE/SPLIT FSM.
module d_mem_lsu #(
    parameter int MEM_SIZE_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic [31:0] dmem_addr,
    output logic        dmem_wr_en,
    output logic [31:0] dmem_wr_data,
    output logic [3:0]  dmem_byte_en,
    input  logic [31:0] dmem_rd_data
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SPLIT = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [31:0] hold_addr_q, hold_addr_d;
    logic [3:0]  hold_be_q, hold_be_d;
    logic [31:0] hold_wdata_q, hold_wdata_d;
    logic [2:0]  hold_funct3_q, hold_funct3_d;
    logic        hold_we_q, hold_we_d;
    logic [31:0] hold_rdata_q, hold_rdata_d;
    logic [4:0]  hold_sh_q, hold_sh_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        resp_err_q, resp_err_d;

    logic [1:0]  off;
    logic [30:0] word_idx;
    logic [3:0]  size_n;
    logic [7:0]  lanes8;
    logic        legal, split, oob, err, accept;
    logic [4:0]  sh_a, sh_b;

    function automatic logic [31:0] extend(input logic [31:0] d, input logic [2:0] f3);
        case (f3)
            3'b000:  extend = {{24{d[7]}}, d[7:0]};
            3'b001:  extend = {{16{d[15]}}, d[15:0]};
            3'b100:  extend = {24'b0, d[7:0]};
            3'b101:  extend = {16'b0, d[15:0]};
            default: extend = d;
        endcase
    endfunction

    always_comb begin
        off      = req_addr[1:0];
        word_idx = {1'b0, req_addr[31:2]};
        case (req_funct3[1:0])
            2'b00:   size_n = 4'd1;
            2'b01:   size_n = 4'd2;
            default: size_n = 4'd4;
        endcase
        legal = req_we ? (req_funct3 == 3'b000 || req_funct3 == 3'b001 || req_funct3 == 3'b010)
                       : (req_funct3 == 3'b000 || req_funct3 == 3'b001 || req_funct3 == 3'b010 ||
                          req_funct3 == 3'b100 || req_funct3 == 3'b101);
        // Upper nibble holds the lanes that spill into the next word.
        lanes8 = ((8'd1 << size_n) - 8'd1) << off;
        split  = |lanes8[7:4];
        oob    = (word_idx >= 31'(MEM_SIZE_WORDS)) ||
                 (split && (word_idx + 31'd1 >= 31'(MEM_SIZE_WORDS)));
        err    = !legal || oob;
        accept = req_valid && (state_q == ST_IDLE);
        sh_a   = {off, 3'b000};
        sh_b   = 5'd0 - sh_a;
    end

    always_comb begin
        state_d       = state_q;
        hold_addr_d   = hold_addr_q;
        hold_be_d     = hold_be_q;
        hold_wdata_d  = hold_wdata_q;
        hold_funct3_d = hold_funct3_q;
        hold_we_d     = hold_we_q;
        hold_rdata_d  = hold_rdata_q;
        hold_sh_d     = hold_sh_q;
        resp_valid_d  = 1'b0;
        resp_data_d   = resp_data_q;
        resp_err_d    = resp_err_q;
        dmem_addr     = 32'd0;
        dmem_wr_en    = 1'b0;
        dmem_wr_data  = 32'd0;
        dmem_byte_en  = 4'd0;
        if (state_q == ST_IDLE) begin
            if (accept && err) begin
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b1;
                resp_data_d  = 32'd0;
            end else if (accept) begin
                dmem_addr    = {1'b0, word_idx};
                dmem_wr_en   = req_we;
                dmem_wr_data = req_wdata << sh_a;
                dmem_byte_en = lanes8[3:0];
                if (split) begin
                    state_d       = ST_SPLIT;
                    hold_addr_d   = {1'b0, word_idx + 31'd1};
                    hold_be_d     = lanes8[7:4];
                    hold_wdata_d  = req_wdata >> sh_b;
                    hold_funct3_d = req_funct3;
                    hold_we_d     = req_we;
                    hold_rdata_d  = dmem_rd_data >> sh_a;
                    hold_sh_d     = sh_b;
                end else begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_data_d  = req_we ? 32'd0 : extend(dmem_rd_data >> sh_a, req_funct3);
                end
            end
        end else begin
            dmem_addr    = hold_addr_q;
            dmem_wr_en   = hold_we_q;
            dmem_wr_data = hold_wdata_q;
            dmem_byte_en = hold_be_q;
            state_d      = ST_IDLE;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_data_d  = hold_we_q ? 32'd0
                         : extend(hold_rdata_q | (dmem_rd_data << hold_sh_q), hold_funct3_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            hold_addr_q   <= 32'd0;
            hold_be_q     <= 4'd0;
            hold_wdata_q  <= 32'd0;
            hold_funct3_q <= 3'd0;
            hold_we_q     <= 1'b0;
            hold_rdata_q  <= 32'd0;
            hold_sh_q     <= 5'd0;
            resp_valid_q  <= 1'b0;
            resp_data_q   <= 32'd0;
            resp_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_addr_q   <= hold_addr_d;
            hold_be_q     <= hold_be_d;
            hold_wdata_q  <= hold_wdata_d;
            hold_funct3_q <= hold_funct3_d;
            hold_we_q     <= hold_we_d;
            hold_rdata_q  <= hold_rdata_d;
            hold_sh_q     <= hold_sh_d;
            resp_valid_q  <= resp_valid_d;
            resp_data_q   <= resp_data_d;
            resp_err_q    <= resp_err_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_d_mem_lsu.sv
// tb/tb_d_mem_lsu.sv - randomized bench for d_mem_lsu against a byte-level memory model.
module tb_d_mem_lsu;
    localparam int MEMW = 64;

    logic        clk, rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_data;
    logic [31:0] dmem_addr, dmem_wr_data, dmem_rd_data;
    logic        dmem_wr_en;
    logic [3:0]  dmem_byte_en;

    d_mem_lsu #(.MEM_SIZE_WORDS(MEMW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .dmem_addr(dmem_addr), .dmem_wr_en(dmem_wr_en), .dmem_wr_data(dmem_wr_data),
        .dmem_byte_en(dmem_byte_en), .dmem_rd_data(dmem_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Attached word memory: combinational read with disabled lanes zeroed.
    logic [31:0] mem [MEMW];
    logic [31:0] ref_mem [MEMW];
    logic [31:0] lane_mask;
    assign lane_mask = {{8{dmem_byte_en[3]}}, {8{dmem_byte_en[2]}}, {8{dmem_byte_en[1]}}, {8{dmem_byte_en[0]}}};
    assign dmem_rd_data = (dmem_addr < MEMW) ? (mem[dmem_addr[5:0]] & lane_mask) : 32'd0;
    always @(posedge clk)
        if (dmem_wr_en && dmem_addr < MEMW)
            for (int b = 0; b < 4; b++)
                if (dmem_byte_en[b]) mem[dmem_addr[5:0]][8*b +: 8] <= dmem_wr_data[8*b +: 8];

    typedef struct { int due; logic [31:0] data; logic err; } exp_t;
    exp_t q[$];
    int tests = 0, fails = 0, cyc = 0;
    logic [31:0] last_data;
    logic        last_err;
    logic [31:0] cap_addr, cap_wd, cap2_addr, cap2_wd;
    logic [3:0]  cap_be, cap2_be;
    logic        cap_we, cap2_we, cap2_ready;
    int          cap_wait;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Request-level model: touch bytes a..a+n-1 in a flat byte view of memory.
    task automatic model_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, output logic split_o);
        int n;
        logic legal, oob;
        logic [32:0] first, last, ba;
        logic [31:0] v;
        exp_t e;
        n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        first = {1'b0, a} >> 2;
        last = ({1'b0, a} + 33'(n - 1)) >> 2;
        oob = (first >= MEMW) || (last >= MEMW);
        split_o = legal && !oob && (first != last);
        e.err = !legal || oob;
        e.data = 32'd0;
        e.due = cyc + 1 + (split_o ? 1 : 0);
        v = 32'd0;
        if (!e.err) begin
            for (int i = 0; i < n; i++) begin
                ba = {1'b0, a} + 33'(i);
                if (we) ref_mem[ba >> 2][8*ba[1:0] +: 8] = wd[8*i +: 8];
                else v[8*i +: 8] = ref_mem[ba >> 2][8*ba[1:0] +: 8];
            end
            if (!we) begin
                case (f3)
                    3'd0: e.data = v[7] ? (v | 32'hFFFFFF00) : v;
                    3'd1: e.data = v[15] ? (v | 32'hFFFF0000) : v;
                    default: e.data = v;
                endcase
            end
        end
        q.push_back(e);
    endtask

    always @(negedge clk) begin : cmp
        exp_t e;
        if (!rst) begin
            if (q.size() > 0 && q[0].due < cyc) begin
                tests++; fails++;
                $display("FAIL resp_missing: no resp_valid at cycle %0d, expected data %h", q[0].due, q[0].data);
                void'(q.pop_front());
            end
            if (resp_valid) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL resp_unexpected: resp_valid with data %h err %0d, none expected", resp_data, resp_err);
                end else begin
                    e = q.pop_front();
                    if (e.due != cyc || e.data !== resp_data || e.err !== resp_err) begin
                        fails++;
                        $display("FAIL resp: got data %h err %0d cycle %0d, expected data %h err %0d cycle %0d",
                                 resp_data, resp_err, cyc, e.data, e.err, e.due);
                    end
                end
                last_data = resp_data;
                last_err  = resp_err;
            end
        end
    end

    // Called just after a falling edge; returns just after the next falling edge after acceptance.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        logic sp;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        #1;
        cap_wait = 0;
        while (!req_ready && cap_wait < 5) begin
            @(negedge clk); #1; cap_wait++;
        end
        if (!req_ready) begin
            tests++; fails++;
            $display("FAIL accept_timeout: req_ready %0d, expected 1", req_ready);
            req_valid = 1'b0;
            @(negedge clk);
            return;
        end
        cap_addr = dmem_addr; cap_be = dmem_byte_en; cap_wd = dmem_wr_data; cap_we = dmem_wr_en;
        model_req(we, f3, a, wd, sp);
        @(posedge clk); #1;
        req_valid = 1'b0;
        cap2_addr = dmem_addr; cap2_be = dmem_byte_en; cap2_wd = dmem_wr_data;
        cap2_we = dmem_wr_en; cap2_ready = req_ready;
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 10; i++) begin
            if (q.size() == 0) break;
            @(negedge clk); #2;
        end
        chk("drain_pending", 32'(q.size()), 32'd0);
    endtask

    initial begin
        logic [2:0] legal_ld [5];
        logic [2:0] f3;
        logic we;
        legal_ld = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int i = 0; i < MEMW; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        @(negedge clk); @(negedge clk);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_dmem_idle", {dmem_addr[27:0], dmem_byte_en}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        chk("sw_addr", cap_addr, 32'd4);
        chk("sw_be", 32'(cap_be), 32'hF);
        chk("sw_wd", cap_wd, 32'hDEADBEEF);
        chk("sw_we", 32'(cap_we), 32'd1);
        issue(1'b0, 3'd2, 32'h10, 32'h0); drain();
        chk("lw_data", last_data, 32'hDEADBEEF);

        issue(1'b1, 3'd2, 32'h0, 32'h83828180);
        chk("b2b_wait0", 32'(cap_wait), 32'd0);
        issue(1'b1, 3'd2, 32'h4, 32'h87868584);
        chk("b2b_wait1", 32'(cap_wait), 32'd0);
        issue(1'b0, 3'd2, 32'h10, 32'h0);
        chk("b2b_wait2", 32'(cap_wait), 32'd0);
        issue(1'b1, 3'd2, 32'h8, 32'h8B8A8988); drain();

        issue(1'b0, 3'd0, 32'h2, 32'h0);
        chk("lb_be", 32'(cap_be), 32'h4);
        drain(); chk("lb_data", last_data, 32'hFFFFFF82);
        issue(1'b0, 3'd4, 32'h2, 32'h0); drain(); chk("lbu_data", last_data, 32'h00000082);
        issue(1'b0, 3'd1, 32'h0, 32'h0); drain(); chk("lh_data", last_data, 32'hFFFF8180);

        issue(1'b0, 3'd2, 32'h6, 32'h0);
        chk("lw_split_a", {cap_addr[27:0], cap_be}, {28'd1, 4'hC});
        chk("lw_split_b", {cap2_addr[27:0], cap2_be}, {28'd2, 4'h3});
        drain(); chk("lw_split_data", last_data, 32'h89888786);

        issue(1'b1, 3'd1, 32'h3, 32'h0000AABB);
        chk("sh_a_addr_be", {cap_addr[27:0], cap_be}, {28'd0, 4'h8});
        chk("sh_a_wd", cap_wd, 32'hBB000000);
        chk("sh_b_addr_be", {cap2_addr[27:0], cap2_be}, {28'd1, 4'h1});
        chk("sh_b_wd", cap2_wd, 32'h000000AA);
        chk("sh_b_ready", 32'(cap2_ready), 32'd0);
        drain();
        chk("sh_word0", mem[0], 32'hBB828180);
        chk("sh_word1", mem[1], 32'h878685AA);

        issue(1'b0, 3'd1, MEMW * 4 - 1, 32'h0);
        chk("oob_dmem", {cap_we, cap_be, cap2_we}, 32'd0);
        drain();
        chk("oob_err", 32'(last_err), 32'd1);
        chk("oob_data", last_data, 32'd0);
        issue(1'b1, 3'd3, 32'h20, 32'h12345678);
        chk("ill_dmem", {cap_we, cap_be}, 32'd0);
        drain();
        chk("ill_err", 32'(last_err), 32'd1);

        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h1; req_wdata = 32'h11223344;
        @(posedge clk); #1;
        rst = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        chk("rst_split_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;
        ref_mem[0][31:8] = 24'h223344;
        repeat (3) @(negedge clk);
        chk("rst_split_w0", mem[0], 32'h22334480);
        chk("rst_split_w1", mem[1], 32'h878685AA);

        for (int i = 0; i < 400; i++) begin
            we = 1'($urandom % 2);
            if ($urandom % 10 < 8) f3 = we ? 3'($urandom % 3) : legal_ld[$urandom % 5];
            else f3 = 3'($urandom % 8);
            issue(we, f3, $urandom_range(0, MEMW * 4 + 8), $urandom);
            if ($urandom % 4 == 0) @(negedge clk);
        end
        drain();
        for (int i = 0; i < MEMW; i++) chk($sformatf("mem_word%0d", i), mem[i], ref_mem[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
